imem_fetch: RTL and testbench

Parametrised instruction memory with a loadable program store and a registered, handshaked fetch port. It sits between the PC/fetch stage and decode. Each accepted request is translated from a byte PC to a word index, checked, read, and answered one cycle later. A HALT word or a faulted fetch parks the block until the core resumes it.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_fetch_if.sv | 29 ++
 rtl/imem_array.sv | 46 ++++
 rtl/imem_fetch.sv | 105 ++++++++++
 tb/tb_imem_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and types for the instruction memory fetch block.
//   HALT_WORD      - instruction encoding that parks the fetch unit
//   FAULT_*        - bit positions inside rsp_fault
//   imem_state_t   - fetch FSM state (RUN / HALTED)
package imem_pkg;

    localparam logic [31:0] HALT_WORD      = 32'h0000_0000;

    localparam int          FAULT_MISALIGN = 0;
    localparam int          FAULT_RANGE    = 1;
    localparam int          FAULT_PARITY   = 2;
    localparam int          FAULT_W        = 3;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_fetch_if.sv
// imem_fetch_if: fetch request/response channel between the PC stage and the
// instruction memory.
//   req_valid/req_ready/req_pc                  - request handshake, byte PC
//   rsp_valid/rsp_ready/rsp_instr/rsp_fault/rsp_halt - response handshake
//   modport master : fetch/decode side (issues requests, consumes responses)
//   modport slave  : instruction memory side
interface imem_fetch_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [PC_W-1:0]   req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [2:0]        rsp_fault;
    logic              rsp_halt;

    modport master (
        output req_valid, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault, rsp_halt
    );

    modport slave (
        input  req_valid, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_fault, rsp_halt
    );
endinterface

// File: rtl/imem_array.sv
// imem_array: DEPTH x DATA_W program store.
//   clk         - write clock
//   we/waddr/wdata - synchronous program load
//   raddr/rdata - combinational read
//   perr        - parity mismatch on the word at raddr
// Optional feature macro: IMEM_PARITY_EN adds one even-parity bit per word,
// generated on load and checked on read. Without it perr is tied to 0.
// Contents power up as all zeros (every word reads as HALT) and are not
// touched by reset.
module imem_array #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              perr
);

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

`ifdef IMEM_PARITY_EN
    // Even parity: stored bit makes the total count of ones even. An all-zero
    // word has parity 0, so the power-up contents are consistent.
    logic par [DEPTH] = '{default: 1'b0};

    always_ff @(posedge clk) begin
        if (we) par[waddr] <= ^wdata;
    end

    assign perr = (^rdata) != par[raddr];
`else
    assign perr = 1'b0;
`endif

endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: instruction memory with loadable program store and a
// registered, handshaked fetch port.
//   clk, rst         - clock, asynchronous active-high reset
//   load_en/addr/data- program load (blocks fetch acceptance that cycle)
//   resume           - leave HALTED
//   halted           - FSM is in HALTED
//   bus (slave)      - fetch request / response channel
// A fetch accepted at edge N is answered from the one-entry response
// register after edge N. A HALT word or any fault parks the block in HALTED.
// Optional feature macro: IMEM_PARITY_EN (parity storage in imem_array).
module imem_fetch
    import imem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    parameter  int PC_W   = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              resume,
    output logic              halted,
    imem_fetch_if.slave       bus
);

    imem_state_t        state;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_instr_q;
    logic [FAULT_W-1:0] rsp_fault_q;
    logic               rsp_halt_q;

    logic [PC_W-1:0]    idx_full;
    logic [DATA_W-1:0]  rd_word;
    logic               perr;
    logic               misalign;
    logic               oor;
    logic               accept;
    logic [FAULT_W-1:0] nx_fault;
    logic [DATA_W-1:0]  nx_instr;
    logic               nx_halt;

    // Range check uses the whole shifted PC so high PC bits cannot alias
    // onto a valid word.
    assign idx_full = bus.req_pc >> 2;
    assign misalign = bus.req_pc[1:0] != 2'b00;
    assign oor      = idx_full >= PC_W'(DEPTH);

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (idx_full[IDX_W-1:0]),
        .rdata (rd_word),
        .perr  (perr)
    );

    always_comb begin
        nx_fault                 = '0;
        nx_fault[FAULT_MISALIGN] = misalign;
        nx_fault[FAULT_RANGE]    = oor;
        // The indexed word is only meaningful for an aligned, in-range PC.
        nx_fault[FAULT_PARITY]   = perr && !misalign && !oor;
        nx_instr                 = (|nx_fault) ? '0 : rd_word;
        nx_halt                  = !(|nx_fault) && (rd_word == DATA_W'(HALT_WORD));
    end

    assign bus.req_ready = (state == RUN) && !load_en && (!rsp_valid_q || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= '0;
            rsp_fault_q <= '0;
            rsp_halt_q  <= 1'b0;
        end else begin
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_instr_q <= nx_instr;
                rsp_fault_q <= nx_fault;
                rsp_halt_q  <= nx_halt;
                if (nx_halt || (|nx_fault)) state <= HALTED;
            end else begin
                if (bus.rsp_ready) rsp_valid_q <= 1'b0;
                // Acceptance only happens in RUN, so resume never races it.
                if (state == HALTED && resume) state <= RUN;
            end
        end
    end

    assign halted        = (state == HALTED);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_halt  = rsp_halt_q;

endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: self-checking bench for imem_fetch. Directed scenarios from
// the block's test plan plus a randomized run against a behavioural model
// (word-array program store, halted flag, one-entry response slot).
module tb_imem_fetch;
    import imem_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int PC_W   = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic        resume;
    logic        halted;

    imem_fetch_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

    imem_fetch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .resume    (resume),
        .halted    (halted),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fault;
        logic        halt;
    } exp_t;

    logic [31:0] mem_m [DEPTH];
    bit          halted_m;

    function automatic exp_t ref_fetch(logic [31:0] pc);
        exp_t e;
        longint unsigned w;
        w       = longint'(pc) / 4;
        e.fault = 3'b000;
        if (pc % 4 != 0) e.fault[0] = 1'b1;
        if (w >= DEPTH)  e.fault[1] = 1'b1;
        if (e.fault != 3'b000) begin
            e.instr = 32'h0;
            e.halt  = 1'b0;
        end else begin
            e.instr = mem_m[w];
            e.halt  = (mem_m[w] == 32'h0);
        end
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.rsp_ready = 1'b1;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        resume        = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic do_resume();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        halted_m = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle();
        #3;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0h want=0", bus.rsp_valid); end
        checks++; if (bus.rsp_instr !== 32'h0) begin errors++; $display("FAIL reset_rsp_instr got=%h want=0", bus.rsp_instr); end
        checks++; if (bus.rsp_fault !== 3'b000) begin errors++; $display("FAIL reset_rsp_fault got=%b want=000", bus.rsp_fault); end
        checks++; if (bus.rsp_halt !== 1'b0) begin errors++; $display("FAIL reset_rsp_halt got=%0h want=0", bus.rsp_halt); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%0h want=0", halted); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%0h want=1", bus.req_ready); end
        load_en = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_load got=%0h want=0", bus.req_ready); end
        load_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        // Power-up contents read as HALT.
        bus.req_valid = 1'b1; bus.req_pc = 32'h10;
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_halt !== 1'b1 || bus.rsp_instr !== 32'h0 || bus.rsp_fault !== 3'b000)
            begin errors++; $display("FAIL zero_init got v=%0h h=%0h i=%h f=%b want v=1 h=1 i=0 f=000", bus.rsp_valid, bus.rsp_halt, bus.rsp_instr, bus.rsp_fault); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL zero_init_halted got=%0h want=1", halted); end
        tick();
        do_resume();
    endtask

    task automatic test_program();
        exp_t e;
        do_load(5'd0, 32'h2008_0004);
        do_load(5'd1, 32'h2009_000F);
        do_load(5'd2, 32'h200A_0014);
        do_load(5'd3, 32'h0000_0000);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = 1'b1; bus.req_pc = 32'(4 * k);
            #1;
            checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL prog_ready[%0d] got=%0h want=1", k, bus.req_ready); end
            @(posedge clk); #1;
            e = ref_fetch(32'(4 * k));
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== e.instr || bus.rsp_fault !== e.fault || bus.rsp_halt !== e.halt)
                begin errors++; $display("FAIL prog_rsp[%0d] got v=%0h i=%h f=%b h=%0h want v=1 i=%h f=%b h=%0h", k, bus.rsp_valid, bus.rsp_instr, bus.rsp_fault, bus.rsp_halt, e.instr, e.fault, e.halt); end
        end
        bus.req_valid = 1'b0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL prog_halted got=%0h want=1", halted); end
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL prog_ready_halted got=%0h want=0", bus.req_ready); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL prog_drain got v=%0h r=%0h want v=0 r=0", bus.rsp_valid, bus.req_ready); end
        do_resume();
        checks++; if (halted !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL prog_resume got h=%0h r=%0h want h=0 r=1", halted, bus.req_ready); end
    endtask

    task automatic test_backpressure();
        bus.req_valid = 1'b1; bus.req_pc = 32'h4; bus.rsp_ready = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got=%0h want=1", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_pc = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'h2009_000F || bus.req_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold[%0d] got v=%0h i=%h r=%0h want v=1 i=2009000f r=0", i, bus.rsp_valid, bus.rsp_instr, bus.req_ready); end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_instr !== 32'h2009_000F) begin errors++; $display("FAIL bp_release got r=%0h i=%h want r=1 i=2009000f", bus.req_ready, bus.rsp_instr); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'h200A_0014 || bus.rsp_fault !== 3'b000)
            begin errors++; $display("FAIL bp_next got v=%0h i=%h f=%b want v=1 i=200a0014 f=000", bus.rsp_valid, bus.rsp_instr, bus.rsp_fault); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0h want=0", bus.rsp_valid); end
    endtask

    task automatic test_faults();
        logic [31:0] pcs [6];
        exp_t e;
        pcs = '{32'h6, 32'h80, 32'h81, 32'h4000_0000, 32'hFFFF_FFFC, 32'h7C};
        foreach (pcs[i]) begin
            bus.req_valid = 1'b1; bus.req_pc = pcs[i];
            #1;
            checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL fault_ready pc=%h got=%0h want=1", pcs[i], bus.req_ready); end
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            e = ref_fetch(pcs[i]);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== e.instr || bus.rsp_fault !== e.fault || bus.rsp_halt !== e.halt)
                begin errors++; $display("FAIL fault_rsp pc=%h got v=%0h i=%h f=%b h=%0h want v=1 i=%h f=%b h=%0h", pcs[i], bus.rsp_valid, bus.rsp_instr, bus.rsp_fault, bus.rsp_halt, e.instr, e.fault, e.halt); end
            checks++; if (halted !== (e.halt || e.fault != 3'b000)) begin errors++; $display("FAIL fault_halted pc=%h got=%0h want=%0h", pcs[i], halted, (e.halt || e.fault != 3'b000)); end
            tick();
            do_resume();
            checks++; if (halted !== 1'b0) begin errors++; $display("FAIL fault_resume pc=%h got=%0h want=0", pcs[i], halted); end
        end
    endtask

    task automatic test_load_collide();
        load_en = 1'b1; load_addr = 5'd2; load_data = 32'hDEAD_BEEF;
        bus.req_valid = 1'b1; bus.req_pc = 32'h8;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL coll_ready got=%0h want=0", bus.req_ready); end
        @(posedge clk); #1;
        mem_m[2] = 32'hDEAD_BEEF;
        load_en = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL coll_ready2 got r=%0h v=%0h want r=1 v=0", bus.req_ready, bus.rsp_valid); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== mem_m[2]) begin errors++; $display("FAIL coll_data got v=%0h i=%h want v=1 i=%h", bus.rsp_valid, bus.rsp_instr, mem_m[2]); end
        tick();
        // Park on the HALT word, load while halted, then resume + load together.
        bus.req_valid = 1'b1; bus.req_pc = 32'hC;
        tick();
        bus.req_valid = 1'b0;
        halted_m = 1'b1;
        do_load(5'd6, 32'h1111_2222);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL load_in_halt got=%0h want=1", halted); end
        resume = 1'b1; load_en = 1'b1; load_addr = 5'd5; load_data = 32'hCAFE_F00D;
        tick();
        resume = 1'b0; load_en = 1'b0; mem_m[5] = 32'hCAFE_F00D; halted_m = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL resume_load got h=%0h r=%0h want h=0 r=1", halted, bus.req_ready); end
        bus.req_valid = 1'b1; bus.req_pc = 32'h14;
        @(posedge clk); #1;
        bus.req_pc = 32'h18;
        checks++; if (bus.rsp_instr !== mem_m[5]) begin errors++; $display("FAIL resume_load_w5 got=%h want=%h", bus.rsp_instr, mem_m[5]); end
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_instr !== mem_m[6] || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL halt_load_w6 got v=%0h i=%h want v=1 i=%h", bus.rsp_valid, bus.rsp_instr, mem_m[6]); end
        tick();
    endtask

    task automatic test_async_reset();
        bus.req_valid = 1'b1; bus.req_pc = 32'hC; bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL arst_pre got v=%0h h=%0h want v=1 h=1", bus.rsp_valid, halted); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL arst_drop got v=%0h h=%0h want v=0 h=0", bus.rsp_valid, halted); end
        halted_m = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b1; bus.req_pc = 32'h0;
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'h2008_0004) begin errors++; $display("FAIL arst_retain got v=%0h i=%h want v=1 i=20080004", bus.rsp_valid, bus.rsp_instr); end
        tick();
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        dut.u_array.par[1] = ~dut.u_array.par[1];
        bus.req_valid = 1'b1; bus.req_pc = 32'h4;
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_fault !== 3'b100 || bus.rsp_instr !== 32'h0 || halted !== 1'b1)
            begin errors++; $display("FAIL parity got f=%b i=%h h=%0h want f=100 i=0 h=1", bus.rsp_fault, bus.rsp_instr, halted); end
        tick();
        do_resume();
    endtask
`endif

    task automatic test_random();
        bit          v_m;
        exp_t        r_m;
        exp_t        e;
        bit          exp_ready;
        bit          acc;
        int          sel;
        for (int a = 0; a < DEPTH; a++)
            do_load(5'(a), ($urandom % 10 == 0) ? 32'h0 : ($urandom | 32'h1));
        rst = 1'b1; #2; rst = 1'b0;
        v_m = 1'b0; halted_m = 1'b0;
        r_m = '{32'h0, 3'b000, 1'b0};
        e   = r_m;
        for (int c = 0; c < 400; c++) begin
            load_en   = ($urandom % 5 == 0);
            load_addr = 5'($urandom);
            load_data = ($urandom % 8 == 0) ? 32'h0 : $urandom;
            resume    = ($urandom % 4 == 0);
            bus.req_valid = ($urandom % 4 != 0);
            sel = $urandom % 8;
            if (sel == 0)      bus.req_pc = $urandom;
            else if (sel == 1) bus.req_pc = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            else               bus.req_pc = 32'($urandom_range(0, 31) * 4);
            bus.rsp_ready = ($urandom % 3 != 0);
            #1;
            exp_ready = !halted_m && !load_en && (!v_m || bus.rsp_ready);
            checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%0h want=%0h", c, bus.req_ready, exp_ready); end
            acc = bus.req_valid && exp_ready;
            if (acc) e = ref_fetch(bus.req_pc);
            @(posedge clk); #1;
            if (acc) begin
                v_m = 1'b1; r_m = e;
                if (e.halt || e.fault != 3'b000) halted_m = 1'b1;
            end else begin
                if (bus.rsp_ready) v_m = 1'b0;
                if (halted_m && resume) halted_m = 1'b0;
            end
            if (load_en) mem_m[load_addr] = load_data;
            checks++; if (bus.rsp_valid !== v_m || halted !== halted_m) begin errors++; $display("FAIL rnd_state c=%0d got v=%0h h=%0h want v=%0h h=%0h", c, bus.rsp_valid, halted, v_m, halted_m); end
            if (v_m) begin
                checks++; if (bus.rsp_instr !== r_m.instr || bus.rsp_fault !== r_m.fault || bus.rsp_halt !== r_m.halt)
                    begin errors++; $display("FAIL rnd_rsp c=%0d got i=%h f=%b h=%0h want i=%h f=%b h=%0h", c, bus.rsp_instr, bus.rsp_fault, bus.rsp_halt, r_m.instr, r_m.fault, r_m.halt); end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) mem_m[a] = 32'h0;
        halted_m = 1'b0;
        test_reset();
        test_program();
        test_backpressure();
        test_faults();
        test_load_collide();
        test_async_reset();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
